// File: rtl/glitch_mon_pkg.sv
// Shared types for the glitch pulse monitor: FSM states, result record layout
// and the drop-counter width.
package glitch_mon_pkg;

  localparam int unsigned DROP_W = 16;
  localparam int unsigned REC_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PULSE
  } state_e;

  // Record layout at the default counter width.
  typedef struct packed {
    logic [REC_W-1:0] width;
    logic [REC_W-1:0] period;
    logic             sat;
  } rec_t;

endpackage

// File: rtl/glitch_pulse_monitor_if.sv
// Result-record stream of the glitch pulse monitor (valid/ready handshake).
interface glitch_pulse_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             M_VALID;
  logic             M_READY;
  logic [CNT_W-1:0] M_WIDTH;
  logic [CNT_W-1:0] M_PERIOD;
  logic             M_SAT;

  modport master (output M_VALID, M_WIDTH, M_PERIOD, M_SAT, input M_READY);
  modport slave  (input M_VALID, M_WIDTH, M_PERIOD, M_SAT, output M_READY);
endinterface

// File: rtl/glitch_pulse_monitor_sync_edge.sv
// Multi-flop synchroniser for the asynchronous pulse pin; resets to the
// pin's inactive level so no spurious pulse is seen out of reset.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/glitch_pulse_monitor.sv
// Measures width and start-to-start period of pulses on an asynchronous pin.
// Optional min/max width statistics are enabled with GLITCH_MON_STATS_EN.
module glitch_pulse_monitor
  import glitch_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned MIN_WIDTH   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   PULSE_IN,
  glitch_pulse_monitor_if.master m,
`ifdef GLITCH_MON_STATS_EN
  input  logic                   STATS_CLR,
  output logic [CNT_W-1:0]       MIN_WIDTH_OUT,
  output logic [CNT_W-1:0]       MAX_WIDTH_OUT,
`endif
  output logic [DROP_W-1:0]      DROP_CNT,
  output logic                   BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_W_CNT = CNT_W'(MIN_WIDTH);

  logic w_s, w_act;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_async(PULSE_IN),
    .o_sync (w_s)
  );

  assign w_act = w_s ^ ACTIVE_LOW;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_width, w_width_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [CNT_W-1:0] r_lat_period, w_lat_period_nxt;
  logic             r_have_start, w_have_start_nxt;
  logic             r_sat, w_sat_nxt, w_sat_set, w_sat_clr;
  logic             w_publish;

  always_comb begin
    w_state_nxt      = r_state;
    w_width_nxt      = r_width;
    w_period_nxt     = r_period;
    w_lat_period_nxt = r_lat_period;
    w_have_start_nxt = r_have_start;
    w_sat_set        = 1'b0;
    w_sat_clr        = 1'b0;
    w_publish        = 1'b0;

    // Period runs from the first recorded start, through WAIT and PULSE alike.
    if (r_state != IDLE && r_have_start && r_period != CNT_MAX) begin
      w_period_nxt = r_period + 1'b1;
      if (w_period_nxt == CNT_MAX) w_sat_set = 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        w_width_nxt      = '0;
        w_period_nxt     = '0;
        w_lat_period_nxt = '0;
        w_have_start_nxt = 1'b0;
        w_sat_clr        = 1'b1;
        if (!w_act) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_act) begin
          w_state_nxt      = PULSE;
          w_width_nxt      = CNT_W'(1);
          w_lat_period_nxt = r_have_start ? r_period : '0;
          w_period_nxt     = CNT_W'(1);
          w_have_start_nxt = 1'b1;
        end
      end
      PULSE: begin
        if (w_act) begin
          if (r_width != CNT_MAX) begin
            w_width_nxt = r_width + 1'b1;
            if (w_width_nxt == CNT_MAX) w_sat_set = 1'b1;
          end
        end else begin
          w_publish   = (r_width >= MIN_W_CNT);
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!EN) begin
      w_state_nxt = IDLE;
      w_publish   = 1'b0;
    end

    w_sat_nxt = ((w_publish || w_sat_clr) ? 1'b0 : r_sat) | w_sat_set;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_width      <= '0;
      r_period     <= '0;
      r_lat_period <= '0;
      r_have_start <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_width      <= w_width_nxt;
      r_period     <= w_period_nxt;
      r_lat_period <= w_lat_period_nxt;
      r_have_start <= w_have_start_nxt;
      r_sat        <= w_sat_nxt;
    end
  end

  logic              r_valid, w_valid_nxt;
  logic [CNT_W-1:0]  r_out_width, w_out_width_nxt;
  logic [CNT_W-1:0]  r_out_period, w_out_period_nxt;
  logic              r_out_sat, w_out_sat_nxt;
  logic [DROP_W-1:0] r_drop, w_drop_nxt;

  always_comb begin
    w_valid_nxt      = r_valid;
    w_out_width_nxt  = r_out_width;
    w_out_period_nxt = r_out_period;
    w_out_sat_nxt    = r_out_sat;
    w_drop_nxt       = r_drop;
    if (r_valid && m.M_READY) w_valid_nxt = 1'b0;
    if (w_publish) begin
      // A pending, unaccepted record wins over the new one.
      if (!r_valid || m.M_READY) begin
        w_valid_nxt      = 1'b1;
        w_out_width_nxt  = r_width;
        w_out_period_nxt = r_lat_period;
        w_out_sat_nxt    = r_sat | w_sat_set;
      end else if (r_drop != {DROP_W{1'b1}}) begin
        w_drop_nxt = r_drop + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid      <= 1'b0;
      r_out_width  <= '0;
      r_out_period <= '0;
      r_out_sat    <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_out_width  <= w_out_width_nxt;
      r_out_period <= w_out_period_nxt;
      r_out_sat    <= w_out_sat_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  assign m.M_VALID  = r_valid;
  assign m.M_WIDTH  = r_out_width;
  assign m.M_PERIOD = r_out_period;
  assign m.M_SAT    = r_out_sat;
  assign DROP_CNT   = r_drop;
  assign BUSY       = (r_state == PULSE);

`ifdef GLITCH_MON_STATS_EN
  logic [CNT_W-1:0] r_min_w, r_max_w;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_min_w <= '1;
      r_max_w <= '0;
    end else if (STATS_CLR) begin
      r_min_w <= '1;
      r_max_w <= '0;
    end else if (w_publish) begin
      if (r_width < r_min_w) r_min_w <= r_width;
      if (r_width > r_max_w) r_max_w <= r_width;
    end
  end

  assign MIN_WIDTH_OUT = r_min_w;
  assign MAX_WIDTH_OUT = r_max_w;
`endif

endmodule

// File: tb/tb_glitch_pulse_monitor.sv
// Directed bench: instance A at default parameters, instance B with CNT_W=8
// and MIN_WIDTH=4. Pin is driven on falling edges so widths are exact.
module tb_glitch_pulse_monitor;
  import glitch_mon_pkg::*;

  logic        clk;
  logic        rst;
  logic        en_a, en_b;
  logic        pin_a, pin_b;
  logic [15:0] drop_a, drop_b;
  logic        busy_a, busy_b;
  int          n_tests;
  int          n_fail;

  glitch_pulse_monitor_if #(.CNT_W(32)) if_a ();
  glitch_pulse_monitor_if #(.CNT_W(8))  if_b ();

`ifdef GLITCH_MON_STATS_EN
  logic        stats_clr;
  logic [31:0] min_a, max_a;
  logic [7:0]  min_b, max_b;
  initial stats_clr = 1'b0;
`endif

  glitch_pulse_monitor u_dut_a (
    .CLK          (clk),
    .RST          (rst),
    .EN           (en_a),
    .PULSE_IN     (pin_a),
    .m            (if_a.master),
`ifdef GLITCH_MON_STATS_EN
    .STATS_CLR    (stats_clr),
    .MIN_WIDTH_OUT(min_a),
    .MAX_WIDTH_OUT(max_a),
`endif
    .DROP_CNT     (drop_a),
    .BUSY         (busy_a)
  );

  glitch_pulse_monitor #(
    .CNT_W    (8),
    .MIN_WIDTH(4)
  ) u_dut_b (
    .CLK          (clk),
    .RST          (rst),
    .EN           (en_b),
    .PULSE_IN     (pin_b),
    .m            (if_b.master),
`ifdef GLITCH_MON_STATS_EN
    .STATS_CLR    (stats_clr),
    .MIN_WIDTH_OUT(min_b),
    .MAX_WIDTH_OUT(max_b),
`endif
    .DROP_CNT     (drop_b),
    .BUSY         (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns the number of falling edges until M_VALID is seen, 0 on timeout.
  task automatic wait_valid(input bit sel, input int budget, output int cycles);
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((sel ? if_b.M_VALID : if_a.M_VALID) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; pin_a = 1'b1; pin_b = 1'b1;
    if_a.M_READY = 1'b0; if_b.M_READY = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({if_a.M_VALID, if_a.M_SAT, busy_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b want 000", {if_a.M_VALID, if_a.M_SAT, busy_a});
    end
    n_tests++;
    if ({if_a.M_WIDTH, if_a.M_PERIOD} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_fields_a: got %h want 0", {if_a.M_WIDTH, if_a.M_PERIOD});
    end
    n_tests++;
    if ({drop_a, drop_b, if_b.M_VALID, busy_b} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_drop_b: got %h want 0", {drop_a, drop_b, if_b.M_VALID, busy_b});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    en_a = 1'b1; en_b = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    if_a.M_READY = 1'b1;
    pin_a = 1'b0;
    repeat (50) @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_busy: got %b want 1", busy_a);
    end
    repeat (45) @(negedge clk);
    pin_a = 1'b1;
    wait_valid(1'b0, 10, cyc);
    n_tests++;
    if (cyc != 3) begin
      n_fail++; $display("FAIL single_latency: got %0d want 3", cyc);
    end
    n_tests++;
    if (if_a.M_WIDTH !== 32'd95 || if_a.M_PERIOD !== 32'd0 || if_a.M_SAT !== 1'b0) begin
      n_fail++;
      $display("FAIL single_record: got w=%0d p=%0d s=%b want w=95 p=0 s=0",
               if_a.M_WIDTH, if_a.M_PERIOD, if_a.M_SAT);
    end
    @(negedge clk);
    n_tests++;
    if (if_a.M_VALID !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_1cyc: got %b want 0", if_a.M_VALID);
    end
  endtask

  task automatic test_period();
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)  pin_a = 1'b0;
      if (i == 95) pin_a = 1'b1;
      @(negedge clk);
    end
    pin_a = 1'b0;
    repeat (95) @(negedge clk);
    pin_a = 1'b1;
    wait_valid(1'b0, 10, cyc);
    n_tests++;
    if (cyc == 0 || if_a.M_PERIOD !== 32'd1000 || if_a.M_WIDTH !== 32'd95) begin
      n_fail++;
      $display("FAIL period_record: got cyc=%0d p=%0d w=%0d want p=1000 w=95",
               cyc, if_a.M_PERIOD, if_a.M_WIDTH);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int widths[3] = '{20, 30, 40};
    if_a.M_READY = 1'b0;
    foreach (widths[k]) begin
      pin_a = 1'b0;
      repeat (widths[k]) @(negedge clk);
      pin_a = 1'b1;
      repeat (30) @(negedge clk);
    end
    n_tests++;
    if (if_a.M_VALID !== 1'b1 || if_a.M_WIDTH !== 32'd20) begin
      n_fail++;
      $display("FAIL held_record: got v=%b w=%0d want v=1 w=20", if_a.M_VALID, if_a.M_WIDTH);
    end
    n_tests++;
    if (drop_a !== 16'd2) begin
      n_fail++; $display("FAIL drop_count: got %0d want 2", drop_a);
    end
    if_a.M_READY = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if_a.M_VALID !== 1'b0 || drop_a !== 16'd2) begin
      n_fail++;
      $display("FAIL drain: got v=%b drop=%0d want v=0 drop=2", if_a.M_VALID, drop_a);
    end
  endtask

  task automatic test_min_width();
    int  cyc;
    bit  seen;
    seen = 1'b0;
    if_b.M_READY = 1'b1;
    pin_b = 1'b0;
    repeat (2) @(negedge clk);
    pin_b = 1'b1;
    for (int i = 2; i < 50; i++) begin
      @(negedge clk);
      if (if_b.M_VALID === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0 || drop_b !== 16'd0) begin
      n_fail++; $display("FAIL short_glitch: got seen=%b drop=%0d want 0 0", seen, drop_b);
    end
    pin_b = 1'b0;
    repeat (10) @(negedge clk);
    pin_b = 1'b1;
    wait_valid(1'b1, 10, cyc);
    n_tests++;
    if (cyc == 0 || if_b.M_WIDTH !== 8'd10 || if_b.M_PERIOD !== 8'd50) begin
      n_fail++;
      $display("FAIL min_width_record: got cyc=%0d w=%0d p=%0d want w=10 p=50",
               cyc, if_b.M_WIDTH, if_b.M_PERIOD);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    repeat (20) @(negedge clk);
    pin_b = 1'b0;
    repeat (300) @(negedge clk);
    pin_b = 1'b1;
    wait_valid(1'b1, 10, cyc);
    n_tests++;
    if (cyc == 0 || if_b.M_WIDTH !== 8'hFF || if_b.M_SAT !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_record: got cyc=%0d w=%0d s=%b want w=255 s=1",
               cyc, if_b.M_WIDTH, if_b.M_SAT);
    end
    repeat (20) @(negedge clk);
    pin_b = 1'b0;
    repeat (20) @(negedge clk);
    pin_b = 1'b1;
    wait_valid(1'b1, 10, cyc);
    n_tests++;
    if (cyc == 0 || if_b.M_WIDTH !== 8'd20 || if_b.M_SAT !== 1'b0 || if_b.M_PERIOD !== 8'hFF) begin
      n_fail++;
      $display("FAIL post_sat_record: got w=%0d s=%b p=%0d want w=20 s=0 p=255",
               if_b.M_WIDTH, if_b.M_SAT, if_b.M_PERIOD);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int cyc;
    bit seen;
    if_a.M_READY = 1'b1;
    pin_a = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL mid_pulse_busy: got %b want 1", busy_a);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({if_a.M_VALID, if_a.M_SAT, busy_a, drop_a} !== 19'd0 ||
        {if_a.M_WIDTH, if_a.M_PERIOD} !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b busy=%b drop=%0d w=%0d want all 0",
               if_a.M_VALID, busy_a, drop_a, if_a.M_WIDTH);
    end
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    en_a = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (if_a.M_VALID === 1'b1 || busy_a === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL armed_in_pulse: got activity=%b want 0", seen);
    end
    pin_a = 1'b1;
    repeat (10) @(negedge clk);
    pin_a = 1'b0;
    repeat (15) @(negedge clk);
    pin_a = 1'b1;
    wait_valid(1'b0, 10, cyc);
    n_tests++;
    if (cyc == 0 || if_a.M_WIDTH !== 32'd15 || if_a.M_PERIOD !== 32'd0) begin
      n_fail++;
      $display("FAIL rearm_record: got cyc=%0d w=%0d p=%0d want w=15 p=0",
               cyc, if_a.M_WIDTH, if_a.M_PERIOD);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_period();
    test_back_to_back();
    test_min_width();
    test_saturation();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
